// File: rtl/dump_pkg.sv
// Shared types and constants for the dump-window scheduler and its frame-accurate helpers.
package dump_pkg;

    typedef enum logic [1:0] {WAIT_DL, ARMED, DUMP, DONE} state_t;

    localparam int DL_TIMEOUT = 1 << 16;
    localparam int WIN_CNT_W  = 8;

    function automatic logic [WIN_CNT_W-1:0] sat_inc(input logic [WIN_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dump_window_ctrl_vs_edge.sv
// Registered falling-edge detector for vertical sync; the tick is held off during reset
// and in the first cycle after reset releases, so a stale vs_l cannot fake a frame.
module vs_edge (
    input  logic clk,
    input  logic rst,
    input  logic vs_i,
    output logic tick_o
);

    logic vs_l_q;
    logic rst_l_q;

    always_ff @(posedge clk) begin
        vs_l_q  <= vs_i;
        rst_l_q <= rst;
    end

    assign tick_o = vs_l_q & ~vs_i & ~rst & ~rst_l_q;

endmodule

// File: rtl/dump_window_ctrl.sv
// Waveform-dump window scheduler: counts frames after ROM download and strobes dump_on/dump_off.
// Optional DUMP_REPEAT_EN adds parameter GAP and reopens the window every GAP frames after a close.
module dump_window_ctrl
    import dump_pkg::*;
#(
`ifdef DUMP_REPEAT_EN
    parameter int unsigned GAP   = 60,
`endif
    parameter int unsigned CW    = 32,
    parameter int unsigned START = 0,
    parameter int unsigned LEN   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vs,
    input  logic                 downloading,
    input  logic                 cfg_ld,
    input  logic [CW-1:0]        cfg_start,
    input  logic [CW-1:0]        cfg_len,
    output logic [CW-1:0]        frame_cnt,
    output logic                 dump_en,
    output logic                 dump_on,
    output logic                 dump_off,
    output logic [WIN_CNT_W-1:0] win_cnt
);

    localparam int TO_W = $clog2(DL_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DL_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        frame_q, frame_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic [CW-1:0]        start_q, start_d;
    logic [CW-1:0]        len_q, len_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 dl_seen_q, dl_seen_d;
    logic                 en_q, en_d;
    logic                 on_q, on_d;
    logic                 off_q, off_d;
    logic [WIN_CNT_W-1:0] win_q, win_d;
`ifdef DUMP_REPEAT_EN
    logic [31:0]          gap_q, gap_d;
`endif

    logic          tick;
    logic [CW-1:0] frame_inc;
    logic [CW-1:0] wcnt_inc;

    vs_edge u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .vs_i   (vs),
        .tick_o (tick)
    );

    assign frame_inc = frame_q + 1'b1;
    assign wcnt_inc  = wcnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_DL;
            frame_q   <= '0;
            wcnt_q    <= '0;
            start_q   <= CW'(START);
            len_q     <= CW'(LEN);
            to_q      <= '0;
            dl_seen_q <= 1'b0;
            en_q      <= 1'b0;
            on_q      <= 1'b0;
            off_q     <= 1'b0;
            win_q     <= '0;
`ifdef DUMP_REPEAT_EN
            gap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            wcnt_q    <= wcnt_d;
            start_q   <= start_d;
            len_q     <= len_d;
            to_q      <= to_d;
            dl_seen_q <= dl_seen_d;
            en_q      <= en_d;
            on_q      <= on_d;
            off_q     <= off_d;
            win_q     <= win_d;
`ifdef DUMP_REPEAT_EN
            gap_q     <= gap_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        wcnt_d    = wcnt_q;
        start_d   = start_q;
        len_d     = len_q;
        to_d      = to_q;
        dl_seen_d = dl_seen_q;
        on_d      = 1'b0;
        off_d     = 1'b0;
        win_d     = win_q;
`ifdef DUMP_REPEAT_EN
        gap_d     = gap_q;
`endif

        // A load takes effect next cycle, so any tick this cycle still sees the old config.
        if (cfg_ld && state_q != DUMP) begin
            start_d = cfg_start;
            len_d   = cfg_len;
        end

        if (state_q != WAIT_DL && downloading) begin
            off_d     = (state_q == DUMP);
            frame_d   = '0;
            dl_seen_d = 1'b1;
            state_d   = WAIT_DL;
        end else begin
            unique case (state_q)
                WAIT_DL: begin
                    dl_seen_d = dl_seen_q | downloading;
                    if (!downloading && (dl_seen_q || to_q == TO_LAST)) begin
                        state_d   = ARMED;
                        dl_seen_d = 1'b0;
                        to_d      = '0;
                    end else if (!dl_seen_q && !downloading) begin
                        to_d = to_q + 1'b1;
                    end
                end
                ARMED: begin
                    if (tick) frame_d = frame_inc;
                    if (start_q == '0 || (tick && frame_inc == start_q)) begin
                        state_d = DUMP;
                        on_d    = 1'b1;
                        wcnt_d  = '0;
                    end
                end
                DUMP: begin
                    if (tick) begin
                        frame_d = frame_inc;
                        wcnt_d  = wcnt_inc;
                        if (len_q != '0 && wcnt_inc == len_q) begin
                            off_d   = 1'b1;
                            win_d   = sat_inc(win_q);
                            state_d = DONE;
`ifdef DUMP_REPEAT_EN
                            gap_d   = '0;
`endif
                        end
                    end
                end
                DONE: begin
                    if (tick) frame_d = frame_inc;
                    if (cfg_ld && cfg_start > frame_q) begin
                        state_d = ARMED;
                    end
`ifdef DUMP_REPEAT_EN
                    else if (tick && len_q != '0) begin
                        if (gap_q + 32'd1 == 32'(GAP)) begin
                            state_d = DUMP;
                            on_d    = 1'b1;
                            wcnt_d  = '0;
                            gap_d   = '0;
                        end else begin
                            gap_d = gap_q + 32'd1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end

        en_d = (state_d == DUMP);
    end

    assign frame_cnt = frame_q;
    assign dump_en   = en_q;
    assign dump_on   = on_q;
    assign dump_off  = off_q;
    assign win_cnt   = win_q;

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Directed bench for dump_window_ctrl: a vector table for the basic window flow plus hand sequences.
module tb_dump_window_ctrl;

    logic        clk;
    logic        rst;
    logic        vs;
    logic        downloading;
    logic        cfg_ld;
    logic [31:0] cfg_start;
    logic [31:0] cfg_len;

    logic [31:0] fc_a;
    logic        en_a, on_a, off_a;
    logic [7:0]  win_a;
    logic [3:0]  fc_b;
    logic        en_b, on_b, off_b;
    logic [7:0]  win_b;

    int n_cmp = 0;
    int n_err = 0;
    int on_cnt = 0;
    int off_cnt = 0;

    dump_window_ctrl #(.CW(32), .START(3), .LEN(2)) dut_a (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .cfg_ld(cfg_ld), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .frame_cnt(fc_a), .dump_en(en_a), .dump_on(on_a), .dump_off(off_a), .win_cnt(win_a)
    );

    dump_window_ctrl #(.CW(4), .START(9), .LEN(0)) dut_b (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .cfg_ld(cfg_ld), .cfg_start(cfg_start[3:0]), .cfg_len(cfg_len[3:0]),
        .frame_cnt(fc_b), .dump_en(en_b), .dump_on(on_b), .dump_off(off_b), .win_cnt(win_b)
    );

`ifdef DUMP_REPEAT_EN
    logic [31:0] fc_c;
    logic        en_c, on_c, off_c;
    logic [7:0]  win_c;
    dump_window_ctrl #(.GAP(3), .CW(32), .START(1), .LEN(2)) dut_c (
        .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
        .cfg_ld(cfg_ld), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .frame_cnt(fc_c), .dump_en(en_c), .dump_on(on_c), .dump_off(off_c), .win_cnt(win_c)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (on_a)  on_cnt  <= on_cnt + 1;
        if (off_a) off_cnt <= off_cnt + 1;
    end

    typedef struct {
        logic        ld;
        logic [31:0] st;
        logic [31:0] ln;
        int          nfr;
        logic [31:0] frame;
        logic        en;
        int          don;
        int          doff;
        logic [7:0]  win;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fall_edge();
        vs = 1'b0;
        step();
    endtask

    task automatic finish_frame(input int per);
        for (int i = 1; i < per / 2; i++) step();
        vs = 1'b1;
        for (int i = 0; i < per - per / 2; i++) step();
    endtask

    task automatic frames(input int n, input int per);
        for (int k = 0; k < n; k++) begin
            fall_edge();
            finish_frame(per);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic load(input logic [31:0] st, input logic [31:0] ln);
        cfg_ld    = 1'b1;
        cfg_start = st;
        cfg_len   = ln;
        step();
        cfg_ld = 1'b0;
    endtask

    task automatic dl_pulse(input int n);
        downloading = 1'b1;
        for (int i = 0; i < n; i++) step();
        downloading = 1'b0;
        step();
        step();
    endtask

    initial begin
        int s_on, s_off;
        vs = 1'b1; rst = 1'b1; downloading = 1'b0;
        cfg_ld = 1'b0; cfg_start = '0; cfg_len = '0;
        step(); step(); step();

        chk("rst frame_cnt", fc_a, 0);
        chk("rst dump_en", en_a, 0);
        chk("rst dump_on", on_a, 0);
        chk("rst dump_off", off_a, 0);
        chk("rst win_cnt", win_a, 0);

        // ld, start, len, frames, frame_cnt, dump_en, on pulses, off pulses, win_cnt
        vecs[0] = '{1'b0, 0,  0, 2,  2, 1'b0, 0, 0, 0};
        vecs[1] = '{1'b0, 0,  0, 1,  3, 1'b1, 1, 0, 0};
        vecs[2] = '{1'b0, 0,  0, 1,  4, 1'b1, 0, 0, 0};
        vecs[3] = '{1'b0, 0,  0, 1,  5, 1'b0, 0, 1, 1};
        vecs[4] = '{1'b0, 0,  0, 3,  8, 1'b0, 0, 0, 1};
        vecs[5] = '{1'b1, 12, 3, 3, 11, 1'b0, 0, 0, 1};
        vecs[6] = '{1'b0, 0,  0, 1, 12, 1'b1, 1, 0, 1};
        vecs[7] = '{1'b0, 0,  0, 2, 14, 1'b1, 0, 0, 1};
        vecs[8] = '{1'b0, 0,  0, 1, 15, 1'b0, 0, 1, 2};
        vecs[9] = '{1'b1, 5,  1, 2, 17, 1'b0, 0, 0, 2};

        // Default config START=3 LEN=2, 1000-clk frames, 100-clk download pulse.
        rst = 1'b0;
        step();
        dl_pulse(100);
        for (int i = 0; i < 10; i++) begin
            s_on  = on_cnt;
            s_off = off_cnt;
            if (vecs[i].ld) load(vecs[i].st, vecs[i].ln);
            frames(vecs[i].nfr, 1000);
            chk($sformatf("vec%0d frame_cnt", i), fc_a, vecs[i].frame);
            chk($sformatf("vec%0d dump_en", i), en_a, vecs[i].en);
            chk($sformatf("vec%0d dump_on count", i), on_cnt - s_on, vecs[i].don);
            chk($sformatf("vec%0d dump_off count", i), off_cnt - s_off, vecs[i].doff);
            chk($sformatf("vec%0d win_cnt", i), win_a, vecs[i].win);
        end

        // start=0 len=0: opens without a tick, stays open, then reset drops everything silently.
        reset_dut();
        load(0, 0);
        downloading = 1'b1;
        for (int i = 0; i < 5; i++) step();
        downloading = 1'b0;
        step();
        chk("s0 on before ARMED eval", on_a, 0);
        step();
        chk("s0 dump_on", on_a, 1);
        chk("s0 dump_en", en_a, 1);
        s_off = off_cnt;
        frames(20, 20);
        chk("s0 dump_en after 20", en_a, 1);
        chk("s0 frame_cnt", fc_a, 20);
        chk("s0 no dump_off", off_cnt - s_off, 0);
        rst = 1'b1;
        step();
        chk("midrst dump_en", en_a, 0);
        chk("midrst dump_off", off_a, 0);
        chk("midrst frame_cnt", fc_a, 0);
        rst = 1'b0;
        step();

        // cfg_ld coincident with the 5th tick.
        reset_dut();
        load(20, 0);
        dl_pulse(5);
        frames(4, 20);
        vs = 1'b0; cfg_ld = 1'b1; cfg_start = 10; cfg_len = 1;
        step();
        cfg_ld = 1'b0;
        chk("coinc frame_cnt", fc_a, 5);
        chk("coinc dump_on", on_a, 0);
        finish_frame(20);
        frames(4, 20);
        chk("coinc en before 10", en_a, 0);
        fall_edge();
        chk("coinc dump_on at 10", on_a, 1);
        chk("coinc frame at 10", fc_a, 10);
        finish_frame(20);
        fall_edge();
        chk("coinc dump_off at 11", off_a, 1);
        chk("coinc en at 11", en_a, 0);
        chk("coinc win_cnt", win_a, 1);
        finish_frame(20);

        // Download restart mid-window.
        reset_dut();
        load(2, 0);
        dl_pulse(5);
        frames(1, 20);
        fall_edge();
        chk("restart open at 2", on_a, 1);
        finish_frame(20);
        frames(2, 20);
        chk("restart en at 4", en_a, 1);
        downloading = 1'b1;
        step();
        chk("restart dump_off", off_a, 1);
        chk("restart dump_en", en_a, 0);
        chk("restart frame_cnt", fc_a, 0);
        chk("restart win_cnt", win_a, 0);
        for (int i = 0; i < 4; i++) step();
        downloading = 1'b0;
        step();
        step();
        frames(1, 20);
        chk("restart frame 1", fc_a, 1);
        chk("restart en 1", en_a, 0);
        fall_edge();
        chk("reopen dump_on", on_a, 1);
        chk("reopen frame", fc_a, 2);
        finish_frame(20);

        // CW=4 wrap: start loaded below the current count reopens after 15->0.
        reset_dut();
        dl_pulse(5);
        frames(5, 20);
        load(2, 1);
        frames(10, 20);
        chk("wrap frame 15", fc_b, 15);
        chk("wrap en at 15", en_b, 0);
        frames(1, 20);
        chk("wrap frame 0", fc_b, 0);
        frames(1, 20);
        chk("wrap frame 1", fc_b, 1);
        fall_edge();
        chk("wrap dump_on", on_b, 1);
        chk("wrap frame 2", fc_b, 2);
        finish_frame(20);

`ifdef DUMP_REPEAT_EN
        begin
            logic exp_en[8];
            exp_en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            reset_dut();
            dl_pulse(5);
            for (int f = 0; f < 8; f++) begin
                frames(1, 20);
                chk($sformatf("repeat en frame %0d", f + 1), en_c, exp_en[f]);
            end
            chk("repeat win_cnt", win_c, 2);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
